// File: rtl/issue_pkg.sv
// Shared definitions for the issue stage: opcodes, RS class decode and the
// reservation-station index used when no station is allocated.
package issue_pkg;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_MUL   = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_LOAD  = 3'd4;
    localparam logic [2:0] OP_STORE = 3'd5;

    typedef enum logic [1:0] {
        CLS_NOP = 2'd0,
        CLS_LS  = 2'd1,
        CLS_ADD = 2'd2,
        CLS_MUL = 2'd3
    } op_class_t;

    function automatic int rs_garbage(input int n_ls, input int n_add, input int n_mul);
        return n_ls + n_add + n_mul + 1;
    endfunction

    // Opcodes 6 and 7 have no functional unit and issue as NOPs.
    function automatic op_class_t op_class(input logic [2:0] op);
        case (op)
            OP_ADD, OP_SUB:   return CLS_ADD;
            OP_MUL, OP_DIV:   return CLS_MUL;
            OP_LOAD, OP_STORE: return CLS_LS;
            default:          return CLS_NOP;
        endcase
    endfunction

endpackage

// File: rtl/rs_pick.sv
// Finds the first clear bit of a busy vector, searching circularly from a
// start index. A zero start gives plain lowest-index priority.
module rs_pick #(
    parameter int N = 3,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  busy,
    input  logic [IW-1:0] start,
    output logic [IW-1:0] grant,
    output logic          found
);

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && !busy[(int'(start) + k) % N]) begin
                found = 1'b1;
                grant = IW'((int'(start) + k) % N);
            end
        end
    end

endmodule

// File: rtl/issue_allocator.sv
// Tomasulo issue stage: allocates a ROB slot and an RS index per instruction.
// Define ISSUE_ALLOC_RR_EN for rotating priority in the ADD and MUL pools.
module issue_allocator
    import issue_pkg::*;
#(
    parameter int ROB_DEPTH = 8,
    parameter int N_LS      = 6,
    parameter int N_ADD     = 3,
    parameter int N_MUL     = 2,
    parameter int RS_W      = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         issue_valid,
    input  logic [2:0]                   op,
    output logic                         issue_ready,
    output logic                         struct_haz,
    input  logic [$clog2(N_LS)-1:0]      ls_entry,
    input  logic                         ls_full,
    input  logic [N_ADD-1:0]             busy_add,
    input  logic [N_MUL-1:0]             busy_mul,
    output logic [$clog2(ROB_DEPTH)-1:0] rob_idx,
    output logic [RS_W-1:0]              rs_idx,
    output logic [$clog2(ROB_DEPTH)-1:0] rob_head,
    output logic [$clog2(ROB_DEPTH):0]   rob_count,
    input  logic                         commit,
    input  logic                         flush,
    output logic                         err_underflow
);

    localparam int AW  = $clog2(ROB_DEPTH);
    localparam int CW  = AW + 1;
    localparam int AIW = (N_ADD > 1) ? $clog2(N_ADD) : 1;
    localparam int MIW = (N_MUL > 1) ? $clog2(N_MUL) : 1;
    localparam logic [RS_W-1:0] GARBAGE = RS_W'(rs_garbage(N_LS, N_ADD, N_MUL));

    logic [AW-1:0]  head;
    logic [AW-1:0]  tail;
    logic [CW-1:0]  count;
    logic           underflow_q;

    logic [AIW-1:0] add_start;
    logic [AIW-1:0] add_grant;
    logic           add_found;
    logic [MIW-1:0] mul_start;
    logic [MIW-1:0] mul_grant;
    logic           mul_found;

    op_class_t      cls;
    logic           class_free;
    logic [RS_W-1:0] pick_idx;
    logic           rob_full;
    logic           fire;
    logic           do_commit;

    rs_pick #(.N(N_ADD)) u_pick_add (
        .busy  (busy_add),
        .start (add_start),
        .grant (add_grant),
        .found (add_found)
    );

    rs_pick #(.N(N_MUL)) u_pick_mul (
        .busy  (busy_mul),
        .start (mul_start),
        .grant (mul_grant),
        .found (mul_found)
    );

    always_comb begin
        cls        = op_class(op);
        class_free = 1'b1;
        pick_idx   = GARBAGE;
        case (cls)
            CLS_LS: begin
                class_free = !ls_full;
                pick_idx   = RS_W'(ls_entry) + RS_W'(1);
            end
            CLS_ADD: begin
                class_free = add_found;
                pick_idx   = RS_W'(N_LS + 1) + RS_W'(add_grant);
            end
            CLS_MUL: begin
                class_free = mul_found;
                pick_idx   = RS_W'(N_LS + N_ADD + 1) + RS_W'(mul_grant);
            end
            default: begin
                class_free = 1'b1;
                pick_idx   = GARBAGE;
            end
        endcase
    end

    // Readiness uses registered occupancy only; a same-cycle commit never frees a slot early.
    assign rob_full    = (count == CW'(ROB_DEPTH));
    assign issue_ready = !rob_full && class_free;
    assign fire        = issue_valid && issue_ready;
    assign struct_haz  = issue_valid && !issue_ready;
    assign do_commit   = commit && (count != '0);

    assign rs_idx        = fire ? pick_idx : GARBAGE;
    assign rob_idx       = tail;
    assign rob_head      = head;
    assign rob_count     = count;
    assign err_underflow = underflow_q;

    // Flush squashes everything in flight, including the instruction offered that cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            underflow_q <= 1'b0;
        end else if (flush) begin
            tail  <= head;
            count <= '0;
        end else begin
            if (fire) begin
                tail <= tail + AW'(1);
            end
            if (do_commit) begin
                head <= head + AW'(1);
            end
            if (commit && (count == '0)) begin
                underflow_q <= 1'b1;
            end
            count <= count + CW'(fire) - CW'(do_commit);
        end
    end

`ifdef ISSUE_ALLOC_RR_EN
    logic [AIW-1:0] add_ptr;
    logic [MIW-1:0] mul_ptr;

    // Next search in a pool begins just past the station it last granted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            add_ptr <= '0;
            mul_ptr <= '0;
        end else if (fire && !flush) begin
            if (cls == CLS_ADD) begin
                add_ptr <= (add_grant == AIW'(N_ADD - 1)) ? '0 : add_grant + AIW'(1);
            end
            if (cls == CLS_MUL) begin
                mul_ptr <= (mul_grant == MIW'(N_MUL - 1)) ? '0 : mul_grant + MIW'(1);
            end
        end
    end

    assign add_start = add_ptr;
    assign mul_start = mul_ptr;
`else
    assign add_start = '0;
    assign mul_start = '0;
`endif

endmodule
